// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Definitions shared by the ID/EX pipeline register, the ID-stage bypass
// network and the write-back stage.
//   SEL_*       : 3-bit write-back source select encodings
//   REG_ADDR_W  : destination address width (bit 5 selects the FP file)
//   ex_data_t   : the data fields carried from ID to EX
package pipeline_pkg;

  localparam int REG_ADDR_W = 6;

  localparam logic [2:0] SEL_ALU = 3'd0;
  localparam logic [2:0] SEL_MEM = 3'd1;
  localparam logic [2:0] SEL_CSR = 3'd2;
  localparam logic [2:0] SEL_PC4 = 3'd3;
  localparam logic [2:0] SEL_FPU = 3'd4;

  // Data fields that are only reloaded when a new instruction is accepted.
  typedef struct packed {
    logic [31:0]           pc;
    logic [31:0]           imm;
    logic [31:0]           rs1_data;
    logic [31:0]           rs2_data;
    logic [31:0]           rs3_data;
    logic [REG_ADDR_W-1:0] rd_addr;
  } ex_data_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   reset : asynchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   cnt   : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
// Pipeline register between decode and execute. Captures bypassed operands
// and decoded control under a valid/ready handshake, inserts a bubble on a
// load-use hazard and kills its contents on flush.
//   clk, reset                   : clock, asynchronous active-high reset
//   valid_ID / ready_ID          : ID-side handshake (ready_ID combinational)
//   rd_after_ld_hazard, flush    : bubble request, pipeline kill
//   pc_ID .. ctrl_ID             : instruction fields from ID
//   valid_EX / ready_EX          : EX-side handshake
//   pc_EX .. ctrl_EX             : registered instruction fields
//   bubble_cnt, flush_cnt        : saturating event statistics
module id_ex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_ID,
  output logic                  ready_ID,
  input  logic                  rd_after_ld_hazard,
  input  logic                  flush,
  input  logic [31:0]           pc_ID,
  input  logic [31:0]           imm_ID,
  input  logic [31:0]           rs1_data_ID,
  input  logic [31:0]           rs2_data_ID,
  input  logic [31:0]           rs3_data_ID,
  input  logic                  rd_wena_ID,
  input  logic [REG_ADDR_W-1:0] rd_addr_ID,
  input  logic [2:0]            wb_src_ID,
  input  logic [CTRL_W-1:0]     ctrl_ID,
  output logic                  valid_EX,
  input  logic                  ready_EX,
  output logic [31:0]           pc_EX,
  output logic [31:0]           imm_EX,
  output logic [31:0]           rs1_data_EX,
  output logic [31:0]           rs2_data_EX,
  output logic [31:0]           rs3_data_EX,
  output logic                  rd_wena_EX,
  output logic [REG_ADDR_W-1:0] rd_addr_EX,
  output logic [2:0]            wb_src_EX,
  output logic [CTRL_W-1:0]     ctrl_EX,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic              valid_reg;
  logic              rd_wena_reg;
  logic [2:0]        wb_src_reg;
  ex_data_t          data_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  logic advance;
  logic empty_slot;
  logic load_en;
  logic bubble_inc;
  logic flush_inc;

  // The slot can take a new value when it is empty or being drained.
  assign advance  = !valid_reg || ready_EX;
  assign ready_ID = advance && !rd_after_ld_hazard && !flush;

  // Flush, bubble and "nothing offered" all leave an invalid slot behind.
  assign empty_slot = flush || (advance && (rd_after_ld_hazard || !valid_ID));
  assign load_en    = ready_ID && valid_ID;

  // A flush outranks a simultaneous hazard, so it suppresses the bubble count.
  assign bubble_inc = advance && rd_after_ld_hazard && !flush;
  assign flush_inc  = flush && valid_reg;

  // Slot-status fields. wb_src is pushed away from SEL_MEM on every invalid
  // slot so the bypass network never sees a phantom load in EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      rd_wena_reg <= 1'b0;
      wb_src_reg  <= SEL_ALU;
    end else if (empty_slot) begin
      valid_reg   <= 1'b0;
      rd_wena_reg <= 1'b0;
      wb_src_reg  <= SEL_ALU;
    end else if (advance) begin
      valid_reg   <= 1'b1;
      rd_wena_reg <= rd_wena_ID;
      wb_src_reg  <= wb_src_ID;
    end
  end

  // Data fields only move on a real load; bubbles and empty slots keep the
  // old values to avoid needless toggling on the wide operand buses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
      ctrl_reg <= '0;
    end else if (load_en) begin
      data_reg.pc       <= pc_ID;
      data_reg.imm      <= imm_ID;
      data_reg.rs1_data <= rs1_data_ID;
      data_reg.rs2_data <= rs2_data_ID;
      data_reg.rs3_data <= rs3_data_ID;
      data_reg.rd_addr  <= rd_addr_ID;
      ctrl_reg          <= ctrl_ID;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc),
    .cnt   (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

  assign valid_EX    = valid_reg;
  assign rd_wena_EX  = rd_wena_reg;
  assign wb_src_EX   = wb_src_reg;
  assign pc_EX       = data_reg.pc;
  assign imm_EX      = data_reg.imm;
  assign rs1_data_EX = data_reg.rs1_data;
  assign rs2_data_EX = data_reg.rs2_data;
  assign rs3_data_EX = data_reg.rs3_data;
  assign rd_addr_EX  = data_reg.rd_addr;
  assign ctrl_EX     = ctrl_reg;

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Pipeline register between the decode (ID) and execute (EX) stages.
- Captures the operands already resolved by the ID-stage bypass network, plus the decoded control fields.
- Hands these to EX under a valid/ready handshake.
- Inserts a bubble whenever the bypass network reports a read-after-load hazard, and kills its contents on a pipeline flush.
- Its `rd_wena_EX`/`rd_addr_EX`/`rd_data`-source fields and `wb_src_EX` are the EX-side inputs of the bypass network, closing the forwarding loop.

## Interface
Parameters:
- `CTRL_W`, default 16: width of the opaque EX control bundle (ALU/FPU op select etc.).
- `CNT_W`, default 32: width of the hazard/flush statistics counters.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `valid_ID` in 1: ID holds a decoded instruction.
- `ready_ID` out 1: register accepts the ID instruction this cycle.
- `rd_after_ld_hazard` in 1: load-use hazard from the bypass network.
- `flush` in 1: kill the instruction in this register and the one offered by ID.
- `pc_ID` in 32: instruction PC.
- `imm_ID` in 32: decoded immediate.
- `rs1_data_ID`, `rs2_data_ID`, `rs3_data_ID` in 32 each: bypassed operands.
- `rd_wena_ID` in 1: destination write enable.
- `rd_addr_ID` in 6: destination address (bit 5 selects the FP file).
- `wb_src_ID` in 3: write-back source select.
- `ctrl_ID` in `CTRL_W`: EX control bundle.
- `valid_EX` out 1: register holds a live instruction.
- `ready_EX` in 1: EX consumes the held instruction this cycle.
- `pc_EX`, `imm_EX`, `rs1_data_EX`, `rs2_data_EX`, `rs3_data_EX` out 32 each: registered copies.
- `rd_wena_EX` out 1: registered write enable; always 0 when `valid_EX` is 0.
- `rd_addr_EX` out 6: registered destination address.
- `wb_src_EX` out 3: registered write-back source.
- `ctrl_EX` out `CTRL_W`: registered control bundle.
- `bubble_cnt` out `CNT_W`: saturating count of hazard bubbles inserted.
- `flush_cnt` out `CNT_W`: saturating count of live instructions killed by flush.

## Operation
- Definition: `advance = !valid_EX || ready_EX`.
- `ready_ID = advance && !rd_after_ld_hazard && !flush`. This path is combinational.
- Per-edge priority, highest first:
  - `flush`: `valid_EX <= 0`, `rd_wena_EX <= 0`, `wb_src_EX <= SEL_ALU`. The flush counter increments if `valid_EX` was 1.
  - `advance && rd_after_ld_hazard`: bubble. `valid_EX <= 0`, `rd_wena_EX <= 0`, `wb_src_EX <= SEL_ALU`. The bubble counter increments. ID holds its instruction.
  - `advance && valid_ID`: load all ID fields, with `valid_EX <= 1`.
  - `advance && !valid_ID`: `valid_EX <= 0`, `rd_wena_EX <= 0`, `wb_src_EX <= SEL_ALU`.
  - Otherwise (`!advance`, stall): hold every field unchanged.
- Bubble and empty cases leave the data fields (`pc`/`imm`/`rs*`/`ctrl`/`rd_addr`) unchanged, to save toggles. Only `valid_EX`, `rd_wena_EX` and `wb_src_EX` are forced.
- Forcing `wb_src_EX` away from `SEL_MEM` on every invalid slot guarantees that an empty slot never produces a spurious `rd_after_ld_hazard`.
- A hazard persists for exactly one bubble: the load moves to MEM on the same edge, and the operand is then forwarded from MEM.
- Counters saturate at all-ones. They do not wrap.

## Timing
- Reset values:
  - `valid_EX` = 0, `rd_wena_EX` = 0, `wb_src_EX` = `SEL_ALU`.
  - `rd_addr_EX` = 0, `ctrl_EX` = 0, `pc_EX`/`imm_EX`/`rs*_data_EX` = 0.
  - `bubble_cnt` = 0, `flush_cnt` = 0.
- Reset is asynchronous and takes effect mid-cycle. Any handshake in flight at that moment is lost.
- Latency: an instruction accepted on edge N is visible on the EX outputs after edge N.
- Throughput: 1 instruction per cycle with no hazard and `ready_EX` = 1.
- `ready_ID` depends combinationally on `ready_EX`, `rd_after_ld_hazard`, `flush` and `valid_EX`. There is no combinational path from the `*_ID` data inputs to any output.
- Simultaneous events:
  - `flush` + hazard: the flush wins. Only the flush counter may increment.
  - Hazard + `!advance`: the stall wins. The register holds and the bubble counter does not increment.

## Structure
- The `pipeline_pkg` package (shared with the bypass network and the write-back stage) holds:
  - the `SEL_ALU`, `SEL_MEM`, `SEL_CSR`, `SEL_PC4`, `SEL_FPU` write-back select constants (3 bits);
  - `REG_ADDR_W` = 6.
- One sub-module: `sat_counter` (parameter `W`; ports `clk`, `reset`, `inc`, `cnt`), instantiated twice.

## Test plan
- Reset mid-stream with `valid_EX` = 1 → next sample: `valid_EX` = 0, `rd_wena_EX` = 0, `wb_src_EX` = `SEL_ALU`, both counters 0.
- Back-to-back ID instructions with PCs 0x100, 0x104, 0x108 and `ready_EX` held at 1 → `pc_EX` shows 0x100, 0x104, 0x108 on consecutive cycles with `valid_EX` = 1 throughout.
- Load in EX (`wb_src_EX` = `SEL_MEM`) with `rd_after_ld_hazard` = 1 for one cycle → `ready_ID` = 0 that cycle, one bubble (`valid_EX` = 0, `rd_wena_EX` = 0), `bubble_cnt` = 1, and the dependent instruction enters on the following edge.
- `ready_EX` = 0 for 3 cycles with `valid_ID` = 1 → all outputs stable, `ready_ID` = 0, no counter change.
- `flush` and `rd_after_ld_hazard` together with `valid_EX` = 1 → `valid_EX` = 0, `flush_cnt` += 1, `bubble_cnt` unchanged.
- `CNT_W` = 2 with 5 consecutive hazard bubbles → `bubble_cnt` stops at 3.
